// File: rtl/start_seq_pkg.sv
// Shared encodings for start_sequencer: FSM states, status codes and LED patterns.
package start_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORE_RST,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } seq_state_e;

    typedef enum logic [1:0] {
        STAT_IDLE  = 2'b00,
        STAT_START = 2'b01,
        STAT_RUN   = 2'b10,
        STAT_END   = 2'b11
    } seq_status_e;

    localparam logic [2:0] LED_IDLE = 3'b001;
    localparam logic [2:0] LED_RUN  = 3'b010;
    localparam logic [2:0] LED_END  = 3'b100;

    function automatic seq_status_e status_of(input seq_state_e s);
        seq_status_e st;
        unique case (s)
            S_IDLE:              st = STAT_IDLE;
            S_CORE_RST, S_LAUNCH: st = STAT_START;
            S_RUN:               st = STAT_RUN;
            default:             st = STAT_END;
        endcase
        return st;
    endfunction

    // Reset/launch share the run LED; done and timeout share the end LED.
    function automatic logic [2:0] led_of(input seq_state_e s);
        logic [2:0] l;
        unique case (s)
            S_IDLE:                      l = LED_IDLE;
            S_CORE_RST, S_LAUNCH, S_RUN: l = LED_RUN;
            default:                     l = LED_END;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchroniser, saturating stability counter and
// rising-edge detect of the debounced level.
module switch_debounce #(
    parameter int unsigned DEB_W = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic deb_o,
    output logic rise_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             deb_prev_q;

    always_comb begin
        cnt_d = '0;
        if (sync2_q) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign deb_o  = &cnt_q;
    assign rise_o = deb_o & ~deb_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            deb_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sw_i;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            deb_prev_q <= deb_o;
        end
    end

endmodule

// File: rtl/start_sequencer.sv
// Switch-started engine sequencer: debounce, pending arbitration, core reset, launch, run.
// Optional RUN watchdog / TIMEOUT state is built when START_SEQ_WATCHDOG_EN is defined.
module start_sequencer
    import start_seq_pkg::*;
#(
    parameter int unsigned  NUM_CH     = 2,
    parameter int unsigned  DEB_W      = 10,
    parameter int unsigned  RST_CYCLES = 16,
    parameter int unsigned  WD_W       = 24,
    localparam int unsigned AW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sw_in,
    input  logic [NUM_CH-1:0] done_in,
    output logic [NUM_CH-1:0] core_rst,
    output logic [NUM_CH-1:0] begin_out,
    output logic [1:0]        status,
    output logic [2:0]        led,
    output logic [AW-1:0]     active_ch,
    output logic              timeout
);

    if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
        $error("start_sequencer: RST_CYCLES must be in 1..255");
    end
    if (WD_W < 1) begin : g_bad_wd_w
        $error("start_sequencer: WD_W must be at least 1");
    end

    logic [NUM_CH-1:0] deb;
    logic [NUM_CH-1:0] rise;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        switch_debounce #(
            .DEB_W(DEB_W)
        ) u_deb (
            .clk_i (clock),
            .rst_ni(rst),
            .sw_i  (sw_in[g]),
            .deb_o (deb[g]),
            .rise_o(rise[g])
        );
    end

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [7:0]        rcnt_q;
    logic [7:0]        rcnt_d;
    logic [AW-1:0]     active_q;
    logic [AW-1:0]     active_d;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] grant;
    logic [AW-1:0]     low_idx;
    logic              low_vld;
    logic              act_deb;
    logic              hold_rst;
    logic              fire;

`ifdef START_SEQ_WATCHDOG_EN
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
`endif

    always_comb begin
        low_idx = '0;
        low_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pending_q[i] && !low_vld) begin
                low_vld = 1'b1;
                low_idx = AW'(i);
            end
        end
    end

    assign act_deb = deb[active_q];

    // A request survives only while its debounced level stays high.
    assign pending_d = (pending_q | rise) & deb & ~grant;

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        active_d = active_q;
        grant    = '0;
        hold_rst = 1'b0;
        fire     = 1'b0;
`ifdef START_SEQ_WATCHDOG_EN
        wd_d     = wd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (low_vld) begin
                    state_d  = S_CORE_RST;
                    active_d = low_idx;
                    rcnt_d   = '0;
                    grant    = NUM_CH'(1) << low_idx;
                end
            end
            S_CORE_RST: begin
                hold_rst = 1'b1;
                if (!act_deb) begin
                    state_d = S_IDLE;
                end else if (rcnt_q == 8'(RST_CYCLES - 1)) begin
                    state_d = S_LAUNCH;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end
            S_LAUNCH: begin
                if (!act_deb) begin
                    hold_rst = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    fire    = 1'b1;
                    state_d = S_RUN;
`ifdef START_SEQ_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            S_RUN: begin
                if (!act_deb) begin
                    hold_rst = 1'b1;
                    state_d  = S_IDLE;
                end else if (done_in[active_q]) begin
                    state_d = S_DONE;
                end
`ifdef START_SEQ_WATCHDOG_EN
                else begin
                    // Expire on the cycle the incremented count reaches all-ones.
                    wd_d = wd_q + 1'b1;
                    if (&wd_d) begin
                        state_d = S_TIMEOUT;
                    end
                end
`endif
            end
            S_DONE, S_TIMEOUT: begin
                if (!act_deb) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_rst  = hold_rst ? (NUM_CH'(1) << active_q) : '0;
    assign begin_out = fire ? (NUM_CH'(1) << active_q) : '0;
    assign status    = status_of(state_q);
    assign led       = led_of(state_q);
    assign active_ch = active_q;

`ifdef START_SEQ_WATCHDOG_EN
    assign timeout = (state_q == S_TIMEOUT);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rcnt_q    <= '0;
            active_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_start_sequencer.sv
// Bench for start_sequencer (NUM_CH=2, DEB_W=4, RST_CYCLES=3, WD_W=6): cycle model
// plus directed latency/abort/reset scenarios and a randomized soak.
module tb_start_sequencer;

    localparam int NUM_CH  = 2;
    localparam int DEB_W   = 4;
    localparam int R       = 3;
    localparam int WD_W    = 6;
    localparam int DEB_MAX = (1 << DEB_W) - 1;
    localparam int WD_MAX  = (1 << WD_W) - 1;
`ifdef START_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic [1:0] sw_in   = '0;
    logic [1:0] done_in = '0;
    logic [1:0] core_rst, begin_out, status;
    logic [2:0] led;
    logic [0:0] active_ch;
    logic       timeout;

    int n_chk  = 0;
    int n_pass = 0;

    start_sequencer #(
        .NUM_CH(NUM_CH), .DEB_W(DEB_W), .RST_CYCLES(R), .WD_W(WD_W)
    ) dut (
        .clock(clock), .rst(rst), .sw_in(sw_in), .done_in(done_in),
        .core_rst(core_rst), .begin_out(begin_out), .status(status),
        .led(led), .active_ch(active_ch), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    endtask

    // ---------------- behavioural model: owner + age since grant ----------------
    int         owner = -1;
    int         last_owner = 0;
    int         age = 0;
    bit         fin = 1'b0;
    bit         tmo = 1'b0;
    logic [1:0] pend = '0;
    logic [1:0] deb_prev = '0;
    int         run_len [NUM_CH];
    logic [1:0] sw_hist [$];

    function automatic logic [1:0] deb_m();
        logic [1:0] d;
        for (int c = 0; c < NUM_CH; c++) d[c] = (run_len[c] >= DEB_MAX);
        return d;
    endfunction

    task automatic model_reset();
        owner = -1; last_owner = 0; age = 0; fin = 1'b0; tmo = 1'b0;
        pend = '0; deb_prev = '0;
        for (int c = 0; c < NUM_CH; c++) run_len[c] = 0;
        sw_hist.delete();
        sw_hist.push_back(2'b00);
        sw_hist.push_back(2'b00);
    endtask

    task automatic model_step();
        logic [1:0] dn, gmask, used;
        dn = deb_m();
        gmask = '0;
        if (owner < 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pend[c] && gmask == 2'b00) begin
                    owner = c; last_owner = c; age = 0; fin = 1'b0; tmo = 1'b0;
                    gmask[c] = 1'b1;
                end
            end
        end else if (!dn[owner]) begin
            owner = -1;
        end else if (!(fin || tmo)) begin
            if (age > R && done_in[owner]) fin = 1'b1;
            else if (WD_EN && age > R && (age - R) == WD_MAX) tmo = 1'b1;
            age++;
        end
        pend = (pend | (dn & ~deb_prev)) & dn & ~gmask;
        deb_prev = dn;
        sw_hist.push_back(sw_in);
        used = sw_hist.pop_front();
        for (int c = 0; c < NUM_CH; c++)
            run_len[c] = used[c] ? ((run_len[c] >= DEB_MAX) ? DEB_MAX : run_len[c] + 1) : 0;
    endtask

    initial model_reset();

    always @(posedge clock or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge clock) begin
        logic [1:0] dn, ecr, ebo;
        int est, eled;
        bit ab;
        dn = deb_m(); ecr = '0; ebo = '0; est = 0; eled = 1;
        if (owner >= 0) begin
            if (fin || tmo) begin
                est = 3; eled = 4;
            end else begin
                ab   = !dn[owner];
                est  = (age <= R) ? 1 : 2;
                eled = 2;
                if (age < R || ab) ecr[owner] = 1'b1;
                if (age == R && !ab) ebo[owner] = 1'b1;
            end
        end
        check("core_rst", int'(core_rst), int'(ecr));
        check("begin_out", int'(begin_out), int'(ebo));
        check("status", int'(status), est);
        check("led", int'(led), eled);
        check("active_ch", int'(active_ch), last_owner);
        check("timeout", int'(timeout), int'(owner >= 0 && tmo));
    end

    // ---------------- directed observation window ----------------
    int wcyc, cr0, cr1, bo0, bo1, run_cyc, first_bo0, first_bo1, first_cr0, ac_bo1;
    int last_st, last_led, last_ac, last_tmo;

    task automatic clear_watch();
        wcyc = 0; cr0 = 0; cr1 = 0; bo0 = 0; bo1 = 0; run_cyc = 0;
        first_bo0 = -1; first_bo1 = -1; first_cr0 = -1; ac_bo1 = -1;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cr0 += int'(core_rst[0]); cr1 += int'(core_rst[1]);
            bo0 += int'(begin_out[0]); bo1 += int'(begin_out[1]);
            if (status == 2'b10) run_cyc++;
            if (core_rst[0] && first_cr0 < 0) first_cr0 = wcyc;
            if (begin_out[0] && first_bo0 < 0) first_bo0 = wcyc;
            if (begin_out[1] && first_bo1 < 0) begin
                first_bo1 = wcyc; ac_bo1 = int'(active_ch);
            end
            last_st = int'(status); last_led = int'(led);
            last_ac = int'(active_ch); last_tmo = int'(timeout);
            wcyc++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout t=%0t got=running want=finished", $time);
        $fatal(1);
    end

    initial begin
        clear_watch();
        repeat (3) @(posedge clock);
        #1;
        check("rst_status", int'(status), 0);
        check("rst_led", int'(led), 1);
        check("rst_core_rst", int'(core_rst), 0);
        check("rst_begin", int'(begin_out), 0);
        rst = 1'b1;

        // Single channel launch from idle.
        clear_watch(); sw_in = 2'b01; watch(30);
        check("t1_first_begin", first_bo0, 22);
        check("t1_core_rst_cycles", cr0, R);
        check("t1_begin_cycles", bo0, 1);
        check("t1_ch1_quiet", cr1 + bo1, 0);
        check("t1_status_run", last_st, 2);
        check("t1_led_run", last_led, 2);
        done_in = 2'b01; watch(2);
        check("t1_status_done", last_st, 3);
        done_in = 2'b00; sw_in = 2'b00; watch(6);
        check("t1_status_idle", last_st, 0);

        // Bouncing switch never debounces.
        clear_watch();
        for (int k = 0; k < 12; k++) begin
            sw_in[0] = ~sw_in[0];
            watch(5);
        end
        sw_in = 2'b00; watch(4);
        check("t2_no_activity", cr0 + bo0 + cr1 + bo1, 0);

        // Both switches together: ch0 first, ch1 after ch0 releases.
        clear_watch(); sw_in = 2'b11; watch(30);
        check("t3_ch0_first", first_bo0, 22);
        check("t3_ch1_waits", bo1, 0);
        done_in = 2'b01; watch(2);
        clear_watch(); done_in = 2'b00; sw_in = 2'b10; watch(30);
        check("t3_ch1_begin_idx", first_bo1, 8);
        check("t3_ch1_active", ac_bo1, 1);
        check("t3_ch0_quiet", cr0 + bo0, 0);
        done_in = 2'b10; watch(2);
        done_in = 2'b00; sw_in = 2'b00; watch(6);

        // Switch dropped while running: abort with one core reset pulse.
        clear_watch(); sw_in = 2'b01; watch(26);
        check("t4_running", last_st, 2);
        clear_watch(); sw_in = 2'b00; watch(8);
        check("t4_abort_cr_cycles", cr0, 1);
        check("t4_abort_cr_idx", first_cr0, 3);
        check("t4_abort_no_begin", bo0, 0);
        check("t4_idle", last_st, 0);

        // Asynchronous reset mid-run, then full re-debounce.
        clear_watch(); sw_in = 2'b10; watch(26);
        check("t5_pre_active", last_ac, 1);
        check("t5_pre_status", last_st, 2);
        @(negedge clock); #2;
        rst = 1'b0; #1;
        check("t5_rst_status", int'(status), 0);
        check("t5_rst_led", int'(led), 1);
        check("t5_rst_active", int'(active_ch), 0);
        check("t5_rst_outs", int'({core_rst, begin_out, timeout}), 0);
        @(posedge clock); #1;
        rst = 1'b1;
        clear_watch(); watch(30);
        check("t5_relaunch_idx", first_bo1, 22);
        done_in = 2'b10; watch(2);
        done_in = 2'b00; sw_in = 2'b00; watch(6);

        // Long run without done: watchdog expiry or plain run.
        clear_watch(); sw_in = 2'b01; watch(100);
        check("t6_run_cycles", run_cyc, WD_EN ? WD_MAX : 77);
        check("t6_timeout", last_tmo, int'(WD_EN));
        check("t6_status", last_st, WD_EN ? 3 : 2);
        sw_in = 2'b00; watch(6);
        check("t6_timeout_clear", last_tmo, 0);
        check("t6_idle", last_st, 0);

        // Randomized soak against the model.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 39) == 0) sw_in[c] = ~sw_in[c];
                done_in[c] = ($urandom_range(0, 24) == 0);
            end
            @(posedge clock); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of switch-started engine channels (ch0 = process, ch1 = transmit).
REQ-002 SHALL have parameter DEB_W, default 10, debounce counter width; a switch counts as stable after 2^DEB_W-1 consecutive high cycles.
REQ-003 SHALL have parameter RST_CYCLES, default 16, number of cycles a channel's core reset is held before launch (range 1..255).
REQ-004 SHALL have parameter WD_W, default 24, watchdog counter width.
REQ-005 clock  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 sw_in  input  NUM_CH  raw, unsynchronised switch levels.
REQ-008 done_in  input  NUM_CH  per-engine finish level, synchronous to clock.
REQ-009 core_rst  output  NUM_CH  active-high reset to each engine.
REQ-010 begin_out  output  NUM_CH  one-cycle launch pulse per engine.
REQ-011 status  output  2  00 idle, 01 reset/launch, 10 run, 11 done/timeout.
REQ-012 led  output  3  one-hot: [0] idle, [1] run (including reset/launch), [2] done/timeout.
REQ-013 active_ch  output  clog2(NUM_CH), minimum 1  index of the channel currently owning the sequencer.
REQ-014 timeout  output  1  sticky watchdog-expiry flag.

Function
REQ-015 Each sw_in bit SHALL pass a 2-flop synchroniser before use.
REQ-016 Per channel, the DEB_W counter SHALL increment while the synchronised switch is high, saturate at all-ones, and clear to 0 on any low cycle.
REQ-017 The debounced level SHALL be 1 exactly while the counter is all-ones; its rising edge SHALL set that channel's pending bit.
REQ-018 Pending bits SHALL be cleared when their channel is granted, or when the debounced level falls before the grant.
REQ-019 FSM states: IDLE, CORE_RST, LAUNCH, RUN, DONE, TIMEOUT.
REQ-020 IDLE -> CORE_RST when any pending bit is set; SHALL grant the lowest pending index and latch it into active_ch.
REQ-021 In CORE_RST, core_rst[active_ch] SHALL be high for exactly RST_CYCLES cycles, then the FSM SHALL move to LAUNCH.
REQ-022 LAUNCH SHALL last one cycle, with begin_out[active_ch]=1, then move to RUN.
REQ-023 In RUN, done_in[active_ch]=1 SHALL move the FSM to DONE on the next edge; done_in bits of other channels SHALL be ignored.
REQ-024 DONE and TIMEOUT SHALL return to IDLE on the first cycle the active channel's debounced level is 0.
REQ-025 Requests arriving in non-IDLE states SHALL stay pending and be served from IDLE in index order, never preempting the active channel.
REQ-026 If the active channel's debounced level falls during CORE_RST, LAUNCH or RUN, the FSM SHALL abort to IDLE with no begin_out and hold core_rst[active_ch] high for 1 cycle.
REQ-027 core_rst and begin_out of non-active channels SHALL be 0 at all times.
REQ-028 Latency from the debounced rising edge to begin_out SHALL be RST_CYCLES+2 cycles when the sequencer is idle.

Reset
REQ-029 While rst=0: FSM=IDLE; counters, pending bits, core_rst, begin_out, active_ch and timeout = 0; status=00; led=001.
REQ-030 Release of rst SHALL NOT by itself create a request; a switch already high SHALL complete the full debounce count.

Configuration
REQ-031 With START_SEQ_WATCHDOG_EN defined, a WD_W counter SHALL clear on entry to RUN and increment in RUN; at all-ones the FSM SHALL go to TIMEOUT, set timeout=1 and hold it until IDLE is re-entered.
REQ-032 Without START_SEQ_WATCHDOG_EN, no watchdog logic SHALL exist, TIMEOUT SHALL be unreachable and timeout SHALL be tied 0.

Structure
REQ-033 The FSM state enum and the status codes SHALL live in a shared package, start_seq_pkg.
REQ-034 The per-channel synchroniser and debouncer SHALL be a sub-module, switch_debounce, instantiated NUM_CH times.

Verification (NUM_CH=2, DEB_W=4, RST_CYCLES=3, WD_W=6)
REQ-035 sw_in[0] high for 20 cycles -> core_rst[0] high 3 cycles, begin_out[0] pulse 1 cycle, status 01->10.
REQ-036 sw_in[0] toggles every 5 cycles for 60 cycles -> no core_rst or begin_out activity.
REQ-037 Both switches rise together -> ch0 completes first; after done_in[0] and sw_in[0] low, ch1 launches with active_ch=1.
REQ-038 In RUN, drop sw_in[0] -> IDLE, core_rst[0] 1-cycle pulse, no begin_out.
REQ-039 Watchdog build, done_in held 0 -> timeout=1 and status=11 after 63 RUN cycles; sw_in[0] low -> IDLE, timeout=0.
REQ-040 rst asserted mid-RUN -> all outputs at reset values in the same cycle; switch held high -> relaunch only after a full 15-cycle debounce.
